// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and stage payload types shared by alu_acc_seq and eight_bit_ALU.
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  typedef struct packed {
    logic       load;
    logic [2:0] sel;
    logic [7:0] b;
  } req_t;

  typedef struct packed {
    logic [7:0] y;
    logic       carry;
    logic       zero;
    logic       err;
  } res_t;
endpackage

// File: rtl/alu_acc_seq_alu.sv
// eight_bit_ALU: combinational 8-bit ALU; carry is add carry-out or sub borrow, 0 otherwise.
module eight_bit_ALU
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] sel,
  output logic [7:0] y,
  output logic       carry
);
  logic [8:0]  sum;
  logic [8:0]  dif;
  logic [15:0] prod;
  assign sum  = {1'b0, a} + {1'b0, b};
  assign dif  = {1'b0, a} - {1'b0, b};
  assign prod = a * b;
  always_comb begin
    y     = 8'h00;
    carry = 1'b0;
    case (sel)
      OP_ADD: {carry, y} = sum;
      OP_SUB: {carry, y} = dif;
      OP_MUL: y = prod[7:0];
      OP_DIV: y = (b == 8'h00) ? 8'h00 : a / b;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      default: y = ~a;
    endcase
  end
endmodule

// File: rtl/alu_acc_seq.sv
// alu_acc_seq: two-stage accumulator sequencer around eight_bit_ALU with valid/ready in and out.
// Optional ALU_SEQ_DIVZ_EN: flag divide-by-zero on out_err and leave acc untouched.
module alu_acc_seq
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_load,
  input  logic [2:0]       in_sel,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_y,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_err,
  output logic [7:0]       acc,
  output logic [CNT_W-1:0] op_cnt
);
  req_t       s1;
  res_t       s2;
  res_t       nxt;
  logic       s1_valid;
  logic       s2_valid;
  logic       adv;
  logic       divz;
  logic [7:0] alu_y;
  logic       alu_c;
  logic [7:0] ny;

  assign adv      = s1_valid & (!s2_valid | out_ready);
  assign in_ready = !s1_valid | !s2_valid | out_ready;

  eight_bit_ALU u_alu (
    .a     (acc),
    .b     (s1.b),
    .sel   (s1.sel),
    .y     (alu_y),
    .carry (alu_c)
  );

`ifdef ALU_SEQ_DIVZ_EN
  assign divz = !s1.load && s1.sel == OP_DIV && s1.b == 8'h00;
`else
  assign divz = 1'b0;
`endif

  assign ny  = s1.load ? s1.b : alu_y;
  assign nxt = '{y: ny, carry: !s1.load & alu_c, zero: ny == 8'h00, err: divz};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      s1_valid <= 1'b0;
      s2       <= '0;
      s2_valid <= 1'b0;
      acc      <= 8'h00;
      op_cnt   <= '0;
    end else begin
      if (in_valid && in_ready) begin
        s1       <= '{load: in_load, sel: in_sel, b: in_b};
        s1_valid <= 1'b1;
      end else if (adv) s1_valid <= 1'b0;
      if (adv) begin
        s2       <= nxt;
        s2_valid <= 1'b1;
        if (!divz) acc <= nxt.y;
      end else if (out_ready) s2_valid <= 1'b0;
      if (s2_valid && out_ready) op_cnt <= op_cnt + CNT_W'(1);
    end
  end

  assign out_valid = s2_valid;
  assign out_y     = s2.y;
  assign out_carry = s2.carry;
  assign out_zero  = s2.zero;
  assign out_err   = s2.err;
endmodule

// File: tb/tb_alu_acc_seq.sv
// tb_alu_acc_seq: table-driven vectors plus hand sequences, checked through an in-order scoreboard.
module tb_alu_acc_seq;
  import alu_pkg::*;

  logic        clk = 0, rst_n = 0, in_valid = 0, in_load = 0, out_ready = 1;
  logic [2:0]  in_sel = 0;
  logic [7:0]  in_b = 0;
  logic        in_ready, out_valid, out_carry, out_zero, out_err;
  logic [7:0]  out_y, acc;
  logic [15:0] op_cnt;

  alu_acc_seq #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_sel(in_sel), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_carry(out_carry), .out_zero(out_zero),
    .out_err(out_err), .acc(acc), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [2:0] sel;
    logic [7:0] b;
    logic [7:0] y;
    logic       c;
  } vec_t;

  vec_t tbl[15];
  res_t q[$];
  res_t mon_e;
  int   n_chk = 0, n_fail = 0, n_pop = 0, n_acc = 0, base = 0;
  logic seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t mk(input logic [7:0] y, input logic c, input logic e);
    return '{y: y, carry: c, zero: (y == 8'h00), err: e};
  endfunction

  function automatic vec_t v(input logic ld, input logic [2:0] sel, input logic [7:0] b,
                             input logic [7:0] y, input logic c);
    return '{ld: ld, sel: sel, b: b, y: y, c: c};
  endfunction

  task automatic send(input logic ld, input logic [2:0] sl, input logic [7:0] b, input res_t e);
    int t = 0;
    in_valid = 1; in_load = ld; in_sel = sl; in_b = b;
    @(negedge clk);
    while (!in_ready && t < 100) begin t++; @(negedge clk); end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: in_ready stuck at 0");
    end else begin
      q.push_back(e);
      n_acc++;
    end
    @(posedge clk); #1 in_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    #1;
    while ((q.size() != 0 || out_valid) && t < 100) begin @(negedge clk); #1; t++; end
    chk("drain_pending", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_result: got y=%0h with empty scoreboard", out_y);
      end else begin
        mon_e = q.pop_front();
        chk("out_y", out_y, mon_e.y);
        chk("out_carry", out_carry, mon_e.carry);
        chk("out_zero", out_zero, mon_e.zero);
        chk("out_err", out_err, mon_e.err);
      end
      n_pop++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = v(1, OP_ADD, 8'h05, 8'h05, 0);
    tbl[1]  = v(0, OP_ADD, 8'h03, 8'h08, 0);
    tbl[2]  = v(1, OP_ADD, 8'hFF, 8'hFF, 0);
    tbl[3]  = v(0, OP_ADD, 8'h01, 8'h00, 1);
    tbl[4]  = v(1, OP_SUB, 8'h03, 8'h03, 0);
    tbl[5]  = v(0, OP_SUB, 8'h05, 8'hFE, 1);
    tbl[6]  = v(0, OP_MUL, 8'h02, 8'hFC, 0);
    tbl[7]  = v(0, OP_DIV, 8'h02, 8'h7E, 0);
    tbl[8]  = v(0, OP_AND, 8'h0F, 8'h0E, 0);
    tbl[9]  = v(0, OP_OR,  8'h30, 8'h3E, 0);
    tbl[10] = v(0, OP_XOR, 8'hFF, 8'hC1, 0);
    tbl[11] = v(0, OP_NOT, 8'h00, 8'h3E, 0);
    tbl[12] = v(0, OP_SUB, 8'h3E, 8'h00, 0);
    tbl[13] = v(0, OP_ADD, 8'h80, 8'h80, 0);
    tbl[14] = v(0, OP_ADD, 8'h90, 8'h10, 1);

    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_acc", acc, 0);
    chk("rst_op_cnt", op_cnt, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_flags", {out_carry, out_zero, out_err}, 0);
    rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      send(tbl[i].ld, tbl[i].sel, tbl[i].b, mk(tbl[i].y, tbl[i].c, 0));
      if (i == 1) begin
        drain();
        chk("op_cnt_after_two", op_cnt, 2);
        chk("acc_after_two", acc, 8'h08);
        @(posedge clk); #1;
      end
    end
    drain();
    chk("acc_after_table", acc, 8'h10);
    chk("op_cnt_after_table", op_cnt, n_pop[15:0]);

    @(posedge clk); #1;
`ifdef ALU_SEQ_DIVZ_EN
    send(1, OP_ADD, 8'h10, mk(8'h10, 0, 0));
    send(0, OP_DIV, 8'h00, mk(8'h00, 0, 1));
    drain();
    chk("divz_acc", acc, 8'h10);
`else
    send(1, OP_ADD, 8'h10, mk(8'h10, 0, 0));
    send(0, OP_DIV, 8'h00, mk(8'h00, 0, 0));
    drain();
    chk("divz_acc", acc, 8'h00);
`endif

    @(posedge clk); #1;
    out_ready = 0;
    base = n_acc;
    fork
      begin
        send(1, OP_ADD, 8'h40, mk(8'h40, 0, 0));
        send(0, OP_ADD, 8'h01, mk(8'h41, 0, 0));
        send(0, OP_ADD, 8'h02, mk(8'h43, 0, 0));
      end
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk); #1;
          if (out_valid) chk("stall_out_y", out_y, 8'h40);
          if (out_valid && n_acc - base == 2 && !seen) begin
            chk("stall_in_ready", in_ready, 0);
            seen = 1;
          end
        end
        chk("stall_out_valid", out_valid, 1);
        chk("stall_acc", acc, 8'h40);
        @(posedge clk); #1 out_ready = 1;
      end
    join
    drain();
    chk("stall_ready_dropped", seen, 1);
    chk("acc_after_stall", acc, 8'h43);
    chk("op_cnt_after_stall", op_cnt, n_pop[15:0]);

    @(posedge clk); #1;
    out_ready = 0;
    send(1, OP_ADD, 8'h55, mk(8'h55, 0, 0));
    send(0, OP_ADD, 8'h01, mk(8'h56, 0, 0));
    @(negedge clk);
    chk("pre_rst_full", {out_valid, in_ready}, 2'b10);
    rst_n = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_op_cnt", op_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    q.delete();
    n_pop = 0;
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    @(posedge clk); #1;
    send(1, OP_ADD, 8'h21, mk(8'h21, 0, 0));
    send(0, OP_ADD, 8'h01, mk(8'h22, 0, 0));
    drain();
    chk("post_rst_op_cnt", op_cnt, 2);
    chk("post_rst_acc", acc, 8'h22);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
